// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//
// Time-multiplexed MAC controller for the I2S FIR path. Each accepted input sample is written
// into a circular delay line. One shared multiplier then steps across all taps, one tap per
// clock, and the result is delivered as one saturated output sample.
//
// Timing: the accepting edge moves the block from IDLE to MAC, and busy rises. The MAC state
// takes NTaps clocks. The last MAC edge registers result and raises resultValid for the single
// OUT cycle. The OUT edge advances the write pointer and returns to IDLE. busy is therefore
// high for NTaps+1 cycles. A sample offered while busy, including on the OUT cycle, is dropped
// and sets the sticky overrun flag.
//
// Build option: define FIR_ROUND_EN to add half an LSB before the final arithmetic shift
// (round-half-up). Without it the shift truncates toward -infinity.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   sampleValid   one-cycle strobe: sampleIn carries a new sample
//   sampleIn      signed input sample
//   coefAddr      coefficient store read address (tap index, 0 outside MAC)
//   coefData      signed Q1.(DataWidth-1) coefficient, combinational read of coefAddr
//   clearOverrun  clears overrun (a simultaneous set wins)
//   busy          high whenever the sequencer is not idle
//   resultValid   one-cycle strobe: result has just been updated
//   result        signed saturated filter output, held until the next update
//   overrun       sticky: an input sample was dropped
module fir_mac_sequencer #(
    parameter int unsigned NTaps     = 13,
    parameter int unsigned DataWidth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sampleValid,
    input  logic [DataWidth-1:0]     sampleIn,
    output logic [$clog2(NTaps)-1:0] coefAddr,
    input  logic [DataWidth-1:0]     coefData,
    input  logic                     clearOverrun,
    output logic                     busy,
    output logic                     resultValid,
    output logic [DataWidth-1:0]     result,
    output logic                     overrun
);

    localparam int unsigned AddrW = $clog2(NTaps);
    localparam int unsigned ProdW = 2 * DataWidth;
    // The width of NTaps full-scale products plus one guard bit per doubling means the
    // accumulator cannot overflow.
    localparam int unsigned AccW  = ProdW + AddrW;

    localparam logic [AddrW-1:0]       LastTap = AddrW'(NTaps - 1);
    localparam logic signed [AccW-1:0] SatMax  = (AccW'(1) <<< (DataWidth - 1)) - AccW'(1);
    localparam logic signed [AccW-1:0] SatMin  = ~SatMax;

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                 state_q;
    logic [DataWidth-1:0]   dline_q [NTaps];
    logic [AddrW-1:0]       wp_q;
    logic [AddrW-1:0]       base_q;
    logic [AddrW-1:0]       tap_q;
    logic signed [AccW-1:0] acc_q;

    logic [AddrW-1:0]       rd_idx;
    logic signed [ProdW-1:0] coef_ext;
    logic signed [ProdW-1:0] samp_ext;
    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0] acc_sum;
    logic signed [AccW-1:0] acc_rnd;
    logic signed [AccW-1:0] acc_shift;
    logic [DataWidth-1:0]   sat_val;

    // Tap k reads the sample k positions older than the newest one. When base - tap goes
    // negative, base + (NTaps - tap) is taken instead; that sum stays below NTaps.
    always_comb begin
        if (base_q >= tap_q) begin
            rd_idx = base_q - tap_q;
        end else begin
            rd_idx = base_q + (LastTap - tap_q) + AddrW'(1);
        end
    end

    // Sign-extend both operands to the full product width so the product is exact.
    assign coef_ext = ProdW'($signed(coefData));
    assign samp_ext = ProdW'($signed(dline_q[rd_idx]));
    assign prod     = coef_ext * samp_ext;
    assign acc_sum  = acc_q + AccW'(prod);

`ifdef FIR_ROUND_EN
    localparam logic signed [AccW-1:0] RoundBias = AccW'(1) <<< (DataWidth - 2);
    assign acc_rnd = acc_sum + RoundBias;
`else
    assign acc_rnd = acc_sum;
`endif

    // Drop the Q1.(DataWidth-1) fraction bits of the coefficient scaling.
    assign acc_shift = acc_rnd >>> (DataWidth - 1);

    always_comb begin
        if (acc_shift > SatMax) begin
            sat_val = SatMax[DataWidth-1:0];
        end else if (acc_shift < SatMin) begin
            sat_val = SatMin[DataWidth-1:0];
        end else begin
            sat_val = acc_shift[DataWidth-1:0];
        end
    end

    // tap_q is returned to zero on leaving MAC, so it can drive the address directly.
    assign coefAddr = tap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wp_q        <= '0;
            base_q      <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            busy        <= 1'b0;
            resultValid <= 1'b0;
            result      <= '0;
            overrun     <= 1'b0;
            for (int i = 0; i < int'(NTaps); i++) begin
                dline_q[i] <= '0;
            end
        end else begin
            resultValid <= 1'b0;

            if (sampleValid && (state_q != StIdle)) begin
                overrun <= 1'b1;
            end else if (clearOverrun) begin
                overrun <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (sampleValid) begin
                        dline_q[wp_q] <= sampleIn;
                        base_q        <= wp_q;
                        tap_q         <= '0;
                        acc_q         <= '0;
                        busy          <= 1'b1;
                        state_q       <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_sum;
                    if (tap_q == LastTap) begin
                        // The final product is folded in combinationally so the result is
                        // ready for the OUT cycle.
                        tap_q       <= '0;
                        result      <= sat_val;
                        resultValid <= 1'b1;
                        state_q     <= StOut;
                    end else begin
                        tap_q <= tap_q + AddrW'(1);
                    end
                end
                StOut: begin
                    wp_q    <= (wp_q == LastTap) ? '0 : wp_q + AddrW'(1);
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
